// File: rtl/cpu_boot_ctrl_if.sv
// Host/memory-side bundle of the boot sequencer: host control and streams plus the cpu's external memory ports.
interface cpu_boot_ctrl_if #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int RUN_W       = 32
);
  logic                   start;
  logic [IMEM_ADDR_W:0]   imem_len;
  logic [DMEM_ADDR_W:0]   dmem_len;
  logic [RUN_W-1:0]       run_cycles;
  logic [DMEM_ADDR_W:0]   dump_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [63:0]            in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [63:0]            out_data;
  logic                   cpu_enable;
  logic [63:0]            addr_ext;
  logic                   wen_ext;
  logic                   ren_ext;
  logic [31:0]            wdata_ext;
  logic [63:0]            addr_ext_2;
  logic                   wen_ext_2;
  logic                   ren_ext_2;
  logic [63:0]            wdata_ext_2;
  logic [63:0]            rdata_ext_2;
  logic                   busy;
  logic                   done;

  modport master (
    output start, imem_len, dmem_len, run_cycles, dump_len,
    output in_valid, in_data, out_ready, rdata_ext_2,
    input  in_ready, out_valid, out_data, cpu_enable,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  busy, done
  );

  modport slave (
    input  start, imem_len, dmem_len, run_cycles, dump_len,
    input  in_valid, in_data, out_ready, rdata_ext_2,
    output in_ready, out_valid, out_data, cpu_enable,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output busy, done
  );
endinterface

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: load imem, load dmem, run the cpu, dump a dmem window to the host.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum beat to the dump stream.
module cpu_boot_ctrl #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int RUN_W       = 32
) (
  input logic             clk,
  input logic             arst,
  cpu_boot_ctrl_if.slave  host_if
);
  localparam int CNT_W = ((IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_OUT,
`ifdef DUMP_CHECKSUM_EN
    S_DUMP_SUM,
`endif
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IMEM_ADDR_W:0]   imem_len_q, imem_len_d;
  logic [DMEM_ADDR_W:0]   dmem_len_q, dmem_len_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [DMEM_ADDR_W:0]   dump_len_q, dump_len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
  logic [63:0]            data_q, data_d;
  logic                   cpu_en_q;
`ifdef DUMP_CHECKSUM_EN
  logic [63:0]            csum_q, csum_d;
`endif

  logic [CNT_W-1:0]       cnt_inc;
  logic                   imem_last, dmem_last, dump_last, run_last;

  // Skipping rule: each helper returns the first stage at or after its own with a nonzero length.
  function automatic state_t dump_entry(input logic [DMEM_ADDR_W:0] dpl);
`ifdef DUMP_CHECKSUM_EN
    return (dpl != '0) ? S_DUMP_RD : S_DUMP_SUM;
`else
    return (dpl != '0) ? S_DUMP_RD : S_DONE;
`endif
  endfunction

  function automatic state_t from_run(input logic [RUN_W-1:0] rc,
                                      input logic [DMEM_ADDR_W:0] dpl);
    return (rc != '0) ? S_RUN : dump_entry(dpl);
  endfunction

  function automatic state_t from_load_d(input logic [DMEM_ADDR_W:0] dl,
                                         input logic [RUN_W-1:0] rc,
                                         input logic [DMEM_ADDR_W:0] dpl);
    return (dl != '0) ? S_LOAD_D : from_run(rc, dpl);
  endfunction

  function automatic state_t from_load_i(input logic [IMEM_ADDR_W:0] il,
                                         input logic [DMEM_ADDR_W:0] dl,
                                         input logic [RUN_W-1:0] rc,
                                         input logic [DMEM_ADDR_W:0] dpl);
    return (il != '0) ? S_LOAD_I : from_load_d(dl, rc, dpl);
  endfunction

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign imem_last = (cnt_inc == CNT_W'(imem_len_q));
  assign dmem_last = (cnt_inc == CNT_W'(dmem_len_q));
  assign dump_last = (cnt_inc == CNT_W'(dump_len_q));
  assign run_last  = (run_cnt_q == (run_q - RUN_W'(1)));

  always_comb begin
    state_d     = state_q;
    imem_len_d  = imem_len_q;
    dmem_len_d  = dmem_len_q;
    run_d       = run_q;
    dump_len_d  = dump_len_q;
    cnt_d       = cnt_q;
    run_cnt_d   = run_cnt_q;
    data_d      = data_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    host_if.in_ready    = 1'b0;
    host_if.wen_ext     = 1'b0;
    host_if.addr_ext    = '0;
    host_if.wdata_ext   = '0;
    host_if.wen_ext_2   = 1'b0;
    host_if.ren_ext_2   = 1'b0;
    host_if.addr_ext_2  = '0;
    host_if.wdata_ext_2 = '0;
    host_if.out_valid   = 1'b0;
    host_if.out_data    = data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (host_if.start) begin
          imem_len_d = host_if.imem_len;
          dmem_len_d = host_if.dmem_len;
          run_d      = host_if.run_cycles;
          dump_len_d = host_if.dump_len;
          cnt_d      = '0;
          run_cnt_d  = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = from_load_i(host_if.imem_len, host_if.dmem_len,
                                   host_if.run_cycles, host_if.dump_len);
        end
      end

      S_LOAD_I: begin
        host_if.in_ready = 1'b1;
        if (host_if.in_valid) begin
          host_if.wen_ext   = 1'b1;
          host_if.addr_ext  = 64'({cnt_q[IMEM_ADDR_W-1:0], 2'b00});
          host_if.wdata_ext = host_if.in_data[31:0];
          if (imem_last) begin
            cnt_d   = '0;
            state_d = from_load_d(dmem_len_q, run_q, dump_len_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_LOAD_D: begin
        host_if.in_ready = 1'b1;
        if (host_if.in_valid) begin
          host_if.wen_ext_2   = 1'b1;
          host_if.addr_ext_2  = 64'({cnt_q[DMEM_ADDR_W-1:0], 3'b000});
          host_if.wdata_ext_2 = host_if.in_data;
          if (dmem_last) begin
            cnt_d   = '0;
            state_d = from_run(run_q, dump_len_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      S_RUN: begin
        if (run_last) begin
          run_cnt_d = '0;
          state_d   = dump_entry(dump_len_q);
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end

      S_DUMP_RD: begin
        host_if.ren_ext_2  = 1'b1;
        host_if.addr_ext_2 = 64'({cnt_q[DMEM_ADDR_W-1:0], 3'b000});
        state_d            = S_DUMP_CAP;
      end

      // Memory read data is valid in this cycle; hold it for the host handshake.
      S_DUMP_CAP: begin
        data_d  = host_if.rdata_ext_2;
        state_d = S_DUMP_OUT;
      end

      S_DUMP_OUT: begin
        host_if.out_valid = 1'b1;
        if (host_if.out_ready) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (dump_last) begin
            cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
            state_d = S_DUMP_SUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_DUMP_RD;
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      S_DUMP_SUM: begin
        host_if.out_valid = 1'b1;
        host_if.out_data  = csum_q;
        if (host_if.out_ready) begin
          state_d = S_DONE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign host_if.ren_ext    = 1'b0;
  assign host_if.cpu_enable = cpu_en_q;
  assign host_if.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign host_if.done       = (state_q == S_DONE);

  // cpu_enable is registered from the next state so it is high exactly while in RUN.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      imem_len_q <= '0;
      dmem_len_q <= '0;
      run_q      <= '0;
      dump_len_q <= '0;
      cnt_q      <= '0;
      run_cnt_q  <= '0;
      data_q     <= '0;
      cpu_en_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      imem_len_q <= imem_len_d;
      dmem_len_q <= dmem_len_d;
      run_q      <= run_d;
      dump_len_q <= dump_len_d;
      cnt_q      <= cnt_d;
      run_cnt_q  <= run_cnt_d;
      data_q     <= data_d;
      cpu_en_q   <= (state_d == S_RUN);
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
endmodule
